// File: rtl/axonerve_kvs_cmd_arbiter.sv
// Round-robin sharing of one axonerve KVS kernel between requesters A and B,
// with an in-order ID FIFO that routes each kernel ACK back to its issuer.
module axonerve_kvs_cmd_arbiter #(
  parameter int DEPTH = 16,
  parameter int KEY_W = 128,
  parameter int VAL_W = 32
) (
  input  logic             I_CLK,
  input  logic             I_XRST,
  input  logic             I_REQ_VALID_A,
  input  logic             I_REQ_VALID_B,
  output logic             O_REQ_READY_A,
  output logic             O_REQ_READY_B,
  input  logic [2:0]       I_REQ_OP_A,
  input  logic [2:0]       I_REQ_OP_B,
  input  logic [KEY_W-1:0] I_REQ_KEY_A,
  input  logic [KEY_W-1:0] I_REQ_KEY_B,
  input  logic [VAL_W-1:0] I_REQ_VAL_A,
  input  logic [VAL_W-1:0] I_REQ_VAL_B,
  input  logic             I_INIT,
  output logic             O_RSP_VALID_A,
  output logic             O_RSP_VALID_B,
  output logic             O_RSP_HIT,
  output logic             O_RSP_ERR,
  output logic [VAL_W-1:0] O_RSP_VAL,
  output logic             O_ILLEGAL_CMD,
  output logic             O_ORPHAN_ACK,
  output logic             O_BUSY,
  output logic             O_KVS_CMD_VALID,
  output logic             O_KVS_CMD_INIT,
  output logic             O_KVS_ERASE,
  output logic             O_KVS_WRITE,
  output logic             O_KVS_READ,
  output logic             O_KVS_SEARCH,
  output logic             O_KVS_UPDATE,
  output logic [KEY_W-1:0] O_KVS_KEY,
  output logic [KEY_W-1:0] O_KVS_MSK,
  output logic [6:0]       O_KVS_PRI,
  output logic [VAL_W-1:0] O_KVS_VAL,
  input  logic             I_KVS_READY,
  input  logic             I_KVS_WAIT,
  input  logic             I_KVS_CMD_FULL,
  input  logic             I_KVS_ACK,
  input  logic             I_KVS_ENT_ERR,
  input  logic             I_KVS_SINGLE_HIT,
  input  logic             I_KVS_MULTIL_HIT,
  input  logic [VAL_W-1:0] I_KVS_VAL
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {ST_WAIT_READY, ST_RUN, ST_DRAIN, ST_INIT} state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    count_reg, count_next;
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic             fifo_mem [DEPTH];
  logic             prefer_b_reg;
  logic             cmd_valid_reg, illegal_reg, orphan_reg, busy_reg;
  logic [4:0]       op_onehot_reg;
  logic [KEY_W-1:0] key_reg;
  logic [VAL_W-1:0] val_reg, rsp_val_reg;
  logic             rsp_valid_a_reg, rsp_valid_b_reg, rsp_hit_reg, rsp_err_reg;

  logic             can_issue, grant_b, accept, op_legal, push, pop, head_id;
  logic [2:0]       sel_op;
  logic [KEY_W-1:0] sel_key;
  logic [VAL_W-1:0] sel_val;

  // I_INIT in RUN blocks issue in the same cycle the drain begins.
  assign can_issue = (state_reg == ST_RUN) && !I_INIT && I_KVS_READY && !I_KVS_WAIT &&
                     !I_KVS_CMD_FULL && (count_reg != CW'(DEPTH));
  assign grant_b   = I_REQ_VALID_B && (!I_REQ_VALID_A || prefer_b_reg);
  assign O_REQ_READY_A = can_issue && !grant_b;
  assign O_REQ_READY_B = can_issue && grant_b;
  assign accept    = (O_REQ_READY_A && I_REQ_VALID_A) || (O_REQ_READY_B && I_REQ_VALID_B);
  assign sel_op    = grant_b ? I_REQ_OP_B  : I_REQ_OP_A;
  assign sel_key   = grant_b ? I_REQ_KEY_B : I_REQ_KEY_A;
  assign sel_val   = grant_b ? I_REQ_VAL_B : I_REQ_VAL_A;
  assign op_legal  = (sel_op <= 3'd4);
  assign push      = accept && op_legal;
  assign pop       = I_KVS_ACK && (count_reg != '0);
  assign head_id   = fifo_mem[rd_ptr_reg];
  assign count_next = count_reg + CW'(push) - CW'(pop);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_WAIT_READY: if (I_KVS_READY) state_next = ST_RUN;
      ST_RUN:        if (I_INIT) state_next = ST_DRAIN;
      ST_DRAIN:      if (count_reg == '0) state_next = ST_INIT;
      ST_INIT:       state_next = ST_WAIT_READY;
      default:       state_next = ST_WAIT_READY;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (push) fifo_mem[wr_ptr_reg] <= grant_b;
  end

  always_ff @(posedge I_CLK or negedge I_XRST) begin
    if (!I_XRST) begin
      state_reg       <= ST_WAIT_READY;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      prefer_b_reg    <= 1'b0;
      cmd_valid_reg   <= 1'b0;
      op_onehot_reg   <= '0;
      key_reg         <= '0;
      val_reg         <= '0;
      illegal_reg     <= 1'b0;
      orphan_reg      <= 1'b0;
      busy_reg        <= 1'b0;
      rsp_valid_a_reg <= 1'b0;
      rsp_valid_b_reg <= 1'b0;
      rsp_hit_reg     <= 1'b0;
      rsp_err_reg     <= 1'b0;
      rsp_val_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      cmd_valid_reg <= push;
      op_onehot_reg <= push ? (5'd1 << sel_op) : 5'd0;
      illegal_reg   <= accept && !op_legal;
      // Registered from next-state values so it tracks the current state/count.
      busy_reg      <= (state_next != ST_RUN) || (count_next != '0);
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (accept) begin
        prefer_b_reg <= !grant_b;
        key_reg      <= sel_key;
        val_reg      <= sel_val;
      end
      if (I_KVS_ACK && count_reg == '0) orphan_reg <= 1'b1;
      rsp_valid_a_reg <= pop && !head_id;
      rsp_valid_b_reg <= pop && head_id;
      if (pop) begin
        rsp_hit_reg <= I_KVS_SINGLE_HIT | I_KVS_MULTIL_HIT;
        rsp_err_reg <= I_KVS_ENT_ERR;
        rsp_val_reg <= I_KVS_VAL;
      end
    end
  end

  assign O_RSP_VALID_A   = rsp_valid_a_reg;
  assign O_RSP_VALID_B   = rsp_valid_b_reg;
  assign O_RSP_HIT       = rsp_hit_reg;
  assign O_RSP_ERR       = rsp_err_reg;
  assign O_RSP_VAL       = rsp_val_reg;
  assign O_ILLEGAL_CMD   = illegal_reg;
  assign O_ORPHAN_ACK    = orphan_reg;
  assign O_BUSY          = busy_reg;
  assign O_KVS_CMD_VALID = cmd_valid_reg;
  assign O_KVS_CMD_INIT  = (state_reg == ST_INIT);
  assign O_KVS_ERASE     = op_onehot_reg[0];
  assign O_KVS_WRITE     = op_onehot_reg[1];
  assign O_KVS_READ      = op_onehot_reg[2];
  assign O_KVS_SEARCH    = op_onehot_reg[3];
  assign O_KVS_UPDATE    = op_onehot_reg[4];
  assign O_KVS_KEY       = key_reg;
  assign O_KVS_MSK       = '0;
  assign O_KVS_PRI       = '0;
  assign O_KVS_VAL       = val_reg;

endmodule
